// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative RV32M multiply/divide unit.
//   - func3 encodings of the M extension (MD_MUL .. MD_REMU)
//   - FSM state enum
//   - is_div(): true for the four divide/remainder encodings
package muldiv_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Divides occupy the upper half of the func3 space.
    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit for the EX stage (RV32M ops).
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   issue handshake; in_ready is high only in IDLE
//   func3, rs1, rs2     operation and operands, rd_in destination tag
//   flush               cancels any in-flight or pending operation
//   out_valid/out_ready result handshake; result and rd_out held in DONE
//   busy                stall request while iterating (BUSY or FIX)
// One 2*XLEN accumulator and one adder/subtractor serve both multiply
// (shift-add, right shifting) and divide (restoring, left shifting).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);

    state_e              r_state;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_opd;
    logic [CW-1:0]       r_cnt;
    logic [2:0]          r_func3;
    logic                r_neg;
    logic [XLEN-1:0]     r_result;
    logic [4:0]          r_rd;

    // ---------------- issue-side decode ----------------
    logic            w_a_signed, w_b_signed, w_neg_a, w_neg_b;
    logic [XLEN-1:0] w_mag_a, w_mag_b;
    logic            w_div_zero, w_ovf;
    logic [XLEN-1:0] w_special_res;

    always_comb begin
        w_a_signed = (func3 == MD_MULH) || (func3 == MD_MULHSU) ||
                     (func3 == MD_DIV)  || (func3 == MD_REM);
        w_b_signed = (func3 == MD_MULH) || (func3 == MD_DIV) || (func3 == MD_REM);
        w_neg_a    = w_a_signed && rs1[XLEN-1];
        w_neg_b    = w_b_signed && rs2[XLEN-1];
        w_mag_a    = w_neg_a ? (~rs1 + XLEN'(1)) : rs1;
        w_mag_b    = w_neg_b ? (~rs2 + XLEN'(1)) : rs2;

        w_div_zero = is_div(func3) && (rs2 == '0);
        w_ovf      = ((func3 == MD_DIV) || (func3 == MD_REM)) &&
                     (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);

        // func3[1] distinguishes REM/REMU from DIV/DIVU.
        w_special_res = '0;
        if (w_div_zero)
            w_special_res = func3[1] ? rs1 : '1;
        else if (w_ovf)
            w_special_res = func3[1] ? '0 : rs1;
    end

    // ---------------- shared adder/subtractor ----------------
    // The sum is XLEN+2 wide so that, when subtracting, the top bit is the
    // "no borrow" flag (partial remainder >= divisor).
    logic              w_sub;
    logic [XLEN:0]     w_add_x, w_add_y;
    logic [XLEN+1:0]   w_add_sum;
    logic [XLEN-1:0]   w_hi, w_lo;
    logic [2*XLEN-1:0] w_iter;

    assign w_hi  = r_acc[2*XLEN-1:XLEN];
    assign w_lo  = r_acc[XLEN-1:0];
    assign w_sub = is_div(r_func3);

    always_comb begin
        // Divide compares the partial remainder after its left shift.
        w_add_x   = w_sub ? r_acc[2*XLEN-1:XLEN-1] : {1'b0, w_hi};
        w_add_y   = w_sub ? ~{1'b0, r_opd} : {1'b0, r_opd};
        w_add_sum = {1'b0, w_add_x} + {1'b0, w_add_y} + {{(XLEN+1){1'b0}}, w_sub};

        if (w_sub) begin
            if (w_add_sum[XLEN+1])
                w_iter = {w_add_sum[XLEN-1:0], w_lo[XLEN-2:0], 1'b1};
            else
                w_iter = {r_acc[2*XLEN-2:XLEN-1], w_lo[XLEN-2:0], 1'b0};
        end else begin
            // Multiplier bits are consumed from the low end; the carry of
            // the partial sum shifts into the top of the accumulator.
            if (w_lo[0])
                w_iter = {w_add_sum[XLEN:0], w_lo[XLEN-1:1]};
            else
                w_iter = {1'b0, w_hi, w_lo[XLEN-1:1]};
        end
    end

    // ---------------- sign fix-up and result select ----------------
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_fix_res;

    always_comb begin
        // Low half of the negated accumulator is also the negated quotient.
        w_prod    = r_neg ? (~r_acc + (2*XLEN)'(1)) : r_acc;
        w_rem_fix = r_neg ? (~w_hi + XLEN'(1)) : w_hi;
        case (r_func3)
            MD_MUL:                       w_fix_res = w_prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: w_fix_res = w_prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              w_fix_res = w_prod[XLEN-1:0];
            default:                      w_fix_res = w_rem_fix;
        endcase
    end

    // ---------------- FSM and datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_opd    <= '0;
            r_cnt    <= '0;
            r_func3  <= MD_MUL;
            r_neg    <= 1'b0;
            r_result <= '0;
            r_rd     <= '0;
        end else if (flush) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_func3 <= func3;
                        r_rd    <= rd_in;
                        // Remainder follows the dividend; everything else
                        // follows the operand sign product.
                        r_neg   <= (is_div(func3) && func3[1]) ? w_neg_a
                                                               : (w_neg_a ^ w_neg_b);
                        if (w_div_zero || w_ovf) begin
                            r_result <= w_special_res;
                            r_state  <= DONE;
                        end else begin
                            r_cnt   <= CW'(XLEN-1);
                            r_state <= BUSY;
                            if (is_div(func3)) begin
                                r_acc <= {{XLEN{1'b0}}, w_mag_a};
                                r_opd <= w_mag_b;
                            end else begin
                                r_acc <= {{XLEN{1'b0}}, w_mag_b};
                                r_opd <= w_mag_a;
                            end
                        end
                    end
                end
                BUSY: begin
                    r_acc <= w_iter;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == '0)
                        r_state <= FIX;
                end
                FIX: begin
                    r_result <= w_fix_res;
                    r_state  <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == BUSY) || (r_state == FIX);
    assign result    = r_result;
    assign rd_out    = r_rd;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

- Parametrised iterative multiply/divide execution unit implementing the RV32M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for a configurable datapath width.
- Sits in the EX stage beside the single-cycle integer ALU. Operations are issued on a valid/ready handshake and run for multiple cycles while the pipeline stalls.
- Results leave on a second valid/ready handshake, tagged with the destination register.
- A branch/jump flush cancels an in-flight operation.

## Interface

Parameters:
- XLEN, 32, operand/result width; legal values are even and ≥ 8.

Ports:
- clk  in  1  clock. All state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  an operation is offered.
- in_ready  out  1  unit can accept; high only in IDLE.
- func3  in  3  M-extension func3 encoding: 000 MUL … 111 REMU.
- rs1  in  XLEN  operand A (multiplicand/dividend).
- rs2  in  XLEN  operand B (multiplier/divisor).
- rd_in  in  5  destination tag, carried through unchanged.
- flush  in  1  cancels any in-flight or pending operation.
- out_valid  out  1  result is available.
- out_ready  in  1  consumer accepts the result.
- result  out  XLEN  operation result.
- rd_out  out  5  tag of the result.
- busy  out  1  high in BUSY or FIX (pipeline stall request).

## Operation

- **States:** IDLE, BUSY, FIX, DONE.
- **IDLE:**
  - Accept when in_valid && in_ready && !flush.
  - Capture func3, rd_in and the operand magnitudes (absolute value for signed operands).
  - Record the result sign.
  - Load counter = XLEN-1.
- **Special cases** (divides only), which go IDLE→DONE directly:
  - Divide by zero (rs2 == 0): DIV/DIVU result = all-ones; REM/REMU result = rs1.
  - Signed overflow (DIV/REM, rs1 = 2^(XLEN-1), rs2 = all-ones): DIV result = rs1; REM result = 0.
- **BUSY:** one iteration per cycle; counter decrements; leave to FIX when counter == 0 at the edge.
  - Multiply: unsigned shift-add into a 2·XLEN accumulator.
  - Divide: restoring shift-subtract, producing an XLEN quotient and an XLEN remainder.
- **FIX:**
  - Apply sign: negate the product if sign(A)^sign(B) for signed operand kinds.
  - Quotient is negated if the operand signs differ (truncation toward zero).
  - Remainder takes the dividend's sign.
  - Select the result: low half for MUL, high half for MULH*, quotient or remainder for divides.
  - Go to DONE.
- **Signedness by op:**
  - MULH: A and B signed.
  - MULHSU: A signed, B unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - MUL: the low half is sign-agnostic.
- **DONE:**
  - out_valid = 1; result and rd_out are held stable.
  - On out_valid && out_ready, go to IDLE.
- **flush** (any state): next state IDLE, out_valid = 0, result discarded.
  - flush has priority over both accept and output handshake in the same cycle.
- All arithmetic is modulo 2^XLEN; the internal product is 2·XLEN bits wide.

## Timing

- **Reset values:** state IDLE, in_ready 1, out_valid 0, busy 0, result 0, rd_out 0, counter 0.
- Reset mid-operation aborts the operation with no output.
- in_ready is a registered function of state; it does not depend combinationally on in_valid.
- **Normal latency:** accept edge → out_valid high after XLEN+2 rising edges (XLEN BUSY cycles + 1 FIX cycle + entry).
- **Special-case latency:** out_valid high on the first edge after accept.
- **Throughput:** at most one operation in flight; no new accept until DONE has handshaked and the unit is back in IDLE.
  - Minimum issue interval is XLEN+3 cycles.
- Holding out_ready low stalls indefinitely in DONE with no change to outputs.
- flush asserted in the DONE cycle where out_ready is also high: the result is not delivered.
  - The consumer must also qualify with flush.

## Structure

- Shared package muldiv_pkg holds:
  - localparams for the func3 encodings (MD_MUL … MD_REMU);
  - the state enum (IDLE, BUSY, FIX, DONE);
  - a helper function is_div(func3).
- Single module; no sub-module. The datapath is one shared accumulator/remainder register plus one XLEN-bit adder/subtractor reused by both multiply and divide.
- Counter width is $clog2(XLEN).

## Test plan

Directed scenarios, XLEN = 32:

- **MUL:** 7 × 0xFFFFFFFD (-3) → result 0xFFFFFFEB; out_valid exactly 34 edges after accept; rd_out equals rd_in (e.g. 5).
- **High-half multiplies:**
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- **Signed/unsigned divides:**
  - DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD.
  - REM -7 % 2 → 0xFFFFFFFF.
  - DIVU 7 / 2 → 3.
  - REMU 0xFFFFFFF9 % 2 → 1.
- **Special cases:**
  - DIV 9 / 0 → 0xFFFFFFFF.
  - REMU 5 % 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
  - All four: out_valid one edge after accept.
- **Flush and back-pressure:**
  - Flush 10 cycles into BUSY → IDLE next edge, in_ready 1, out_valid never asserts; a following MUL 3 × 4 → 12.
  - out_ready held low for 5 cycles in DONE → result/rd_out stable; handshake on cycle 6.
- **Reset and accept gating:**
  - rst asserted mid-BUSY → all outputs at reset values the next edge.
  - in_valid && flush in IDLE → no accept.
